// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: line fetch with fixed memory latency, 4x16-bit split, redirect
module fetch_unit #(
  parameter int          MEM_LATENCY = 5,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [63:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [15:1]   pc;
  logic [15:1]   pc_next;
  logic [63:0]   line_buf;
  logic [63:0]   line_buf_next;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_next;

  logic [12:0]   line;
  logic [1:0]    slot;
  logic [15:0]   target;
  logic          line_change;
  logic          handshake;
  logic          cnt_done;

  assign line        = pc[15:3];
  assign slot        = pc[2:1];
  // Bit 0 of the redirect target is meaningless for 16-bit instructions.
  assign target      = redirect_pc & 16'hFFFE;
  assign line_change = (target[15:3] != line);
  assign handshake   = (state == DELIVER) && instr_ready;
  assign cnt_done    = (wait_cnt == CW'(MEM_LATENCY));

  // State register; reset lands in BOOT so the first real address is seen as a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: redirect dominates, otherwise latency count or line exhaustion.
  always_comb begin
    state_next = state;
    case (state)
      BOOT: state_next = WAIT;
      WAIT: begin
        if (redirect_valid && line_change) begin
          state_next = WAIT;
        end else if (cnt_done) begin
          state_next = DELIVER;
        end
      end
      DELIVER: begin
        if (redirect_valid) begin
          state_next = line_change ? WAIT : DELIVER;
        end else if (handshake && (slot == 2'd3)) begin
          state_next = WAIT;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // Datapath next values: pc, latency counter and line capture.
  always_comb begin
    pc_next       = pc;
    line_buf_next = line_buf;
    wait_cnt_next = wait_cnt;
    case (state)
      BOOT: begin
        wait_cnt_next = '0;
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_next = target[15:1];
        end
        if (redirect_valid && line_change) begin
          // A new line restarts the memory's latency window.
          wait_cnt_next = '0;
        end else if (cnt_done) begin
          line_buf_next = imem_data;
        end else begin
          // A same-line redirect leaves the memory phase untouched.
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end
      DELIVER: begin
        if (redirect_valid) begin
          pc_next = target[15:1];
          if (line_change) begin
            wait_cnt_next = '0;
          end
        end else if (handshake) begin
          // Slot increment carries into the line number, wrapping at the top of memory.
          pc_next = pc + 15'd1;
          if (slot == 2'd3) begin
            wait_cnt_next = '0;
          end
        end
      end
      default: begin
        wait_cnt_next = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC[15:1];
      line_buf <= '0;
      wait_cnt <= '0;
    end else begin
      pc       <= pc_next;
      line_buf <= line_buf_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Outputs: BOOT presents the line next to RESET_PC so the first real address differs.
  always_comb begin
    imem_addr   = {line, 3'b000};
    instr_valid = (state == DELIVER);
    instr       = line_buf[{slot, 4'b0000} +: 16];
    instr_pc    = {pc, 1'b0};
    if (state == BOOT) begin
      imem_addr = {RESET_PC[15:3] ^ 13'h1, 3'b000};
    end
  end

endmodule
